dff_bank_arbiter: RTL

DFF_BANK_ARBITER -- requirements
Module: dff_bank_arbiter

---
 rtl/dff_bank_arbiter_if.sv | 15 +
 rtl/dff_bank_arbiter.sv | 96 +++++++++
 2 files changed

// File: rtl/dff_bank_arbiter_if.sv
// Shared-register write bus: level requests with packed per-requester data in, grant/ack/contents out.
interface dff_bank_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       ack;
  logic [WIDTH-1:0]       q;
  logic                   busy;

  modport master (output req, wdata, input gnt, ack, q, busy);
  modport slave  (input req, wdata, output gnt, ack, q, busy);
endinterface

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter serializing four requesters' writes into one shared register bank.
// Grant 1 cycle after req, write + 1-cycle ack on the next edge; requests wait (held) while busy.
module dff_bank_arbiter #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4
) (
  input logic               clk,
  input logic               sync_reset,
  dff_bank_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GRANT, COMMIT} state_t;

  state_t           state, state_nxt;
  logic [1:0]       ptr, ptr_nxt;
  logic [1:0]       sel, sel_nxt;
  logic [1:0]       winner;
  logic             any_req;
  logic [N_REQ-1:0] gnt, gnt_nxt;
  logic [N_REQ-1:0] ack, ack_nxt;
  logic [WIDTH-1:0] q, q_nxt;

  // Descending scan so the requester closest to ptr is the last (winning) assignment.
  always_comb begin
    winner  = ptr;
    any_req = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.req[ptr + 2'(k)]) begin
        winner  = ptr + 2'(k);
        any_req = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state <= IDLE;
      ptr   <= '0;
      sel   <= '0;
      gnt   <= '0;
      ack   <= '0;
      q     <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      sel   <= sel_nxt;
      gnt   <= gnt_nxt;
      ack   <= ack_nxt;
      q     <= q_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = GRANT;
      GRANT:   state_nxt = bus.req[sel] ? COMMIT : IDLE;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ptr_nxt = ptr;
    sel_nxt = sel;
    gnt_nxt = gnt;
    ack_nxt = '0;
    q_nxt   = q;
    case (state)
      IDLE: begin
        if (any_req) begin
          sel_nxt = winner;
          gnt_nxt = N_REQ'(1) << winner;
        end
      end
      GRANT: begin
        // A withdrawn request abandons the slot without moving the pointer.
        if (bus.req[sel]) begin
          q_nxt   = bus.wdata[int'(sel)*WIDTH +: WIDTH];
          ack_nxt = N_REQ'(1) << sel;
        end else begin
          gnt_nxt = '0;
        end
      end
      COMMIT: begin
        gnt_nxt = '0;
        ptr_nxt = sel + 2'd1;
      end
      default: gnt_nxt = '0;
    endcase
  end

  assign bus.gnt  = gnt;
  assign bus.ack  = ack;
  assign bus.q    = q;
  assign bus.busy = (state != IDLE);
endmodule
